// File: rtl/mips_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_div_unit_pkg
// Description : Shared constants for the MIPS DIV/DIVU execution unit.
//               Holds the FSM state encoding, the datapath width and the
//               quotient value returned for a divide by zero.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Quotient reported when the divisor is zero
  localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage : mips_div_unit_pkg
`default_nettype wire

// File: rtl/mips_div_unit_leading_0_counter.sv
`default_nettype none
// ============================================================================
// Module      : leading_0_counter
// Description : Combinational count of leading zeros of a 32-bit word.
//               Result range is 0..32 (32 for an all-zero input).
// Ports       : ena      - enable; output forced to 0 when low
//               data_in  - word to examine
//               data_out - number of leading zeros
// Revision    : 1.0 - initial release
// ============================================================================
module leading_0_counter (
  input  logic        ena,
  input  logic [31:0] data_in,
  output logic [5:0]  data_out
);

  logic [5:0] cnt;

  // Scan from the LSB upward so the highest set bit is the last to write.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (data_in[i]) begin
        cnt = 6'(31 - i);
      end
    end
    data_out = ena ? cnt : 6'd0;
  end

endmodule : leading_0_counter
`default_nettype wire

// File: rtl/mips_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_div_unit
// Description : Multi-cycle DIV/DIVU unit for the MIPS EX stage. The dividend
//               magnitude is normalised with a leading-zero count, then a
//               restoring radix-2 loop runs only over the significant bits.
// Ports       : clk, rst_n            - clock, async active-low reset
//               start, is_signed      - launch request, 1 = DIV / 0 = DIVU
//               dividend, divisor     - rs / rt operands
//               flush                 - synchronous abort
//               busy, done            - status (stall / completion pulse)
//               quotient, remainder   - LO / HI results, held
//               div_by_zero           - divisor was zero, held with results
// Revision    : 1.0 - initial release
// ============================================================================
module mips_div_unit
  import mips_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude / shift register
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] q_q, q_d;         // quotient magnitude being built
  logic             sgn_dvd_q, sgn_dvd_d;
  logic             sgn_dvs_q, sgn_dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [5:0]       lz;
  logic [CNT_W-1:0] n_bits;
  logic [WIDTH:0]   r_ext;            // one extra bit: 2*r + b can exceed 32 bits
  logic             q_bit;

  leading_0_counter u_lzc (
    .ena      (1'b1),
    .data_in  (dvd_q),
    .data_out (lz)
  );

  assign n_bits = CNT_W'(WIDTH) - CNT_W'(lz);

  always_comb begin
    state_d       = state_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    rem_d         = rem_q;
    q_d           = q_q;
    sgn_dvd_d     = sgn_dvd_q;
    sgn_dvs_d     = sgn_dvs_q;
    cnt_d         = cnt_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    r_ext         = {rem_q, dvd_q[WIDTH-1]};
    q_bit         = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          sgn_dvd_d = is_signed & dividend[WIDTH-1];
          sgn_dvs_d = is_signed & divisor[WIDTH-1];
          dvd_d     = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
          dvs_d     = (is_signed & divisor[WIDTH-1])  ? -divisor  : divisor;
          state_d   = ST_PREP;
        end
      end

      ST_PREP: begin
        rem_d = '0;
        q_d   = '0;
        cnt_d = n_bits;
        if (dvs_q == '0) begin
          // Keep the magnitude unshifted: FIX rebuilds the raw dividend from it.
          state_d = ST_FIX;
        end else begin
          dvd_d   = dvd_q << lz;
          state_d = (n_bits == '0) ? ST_FIX : ST_ITER;
        end
      end

      ST_ITER: begin
        q_bit = (r_ext >= {1'b0, dvs_q});
        rem_d = q_bit ? (r_ext[WIDTH-1:0] - dvs_q) : r_ext[WIDTH-1:0];
        dvd_d = dvd_q << 1;
        q_d   = {q_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (dvs_q == '0) begin
          quotient_d    = DZ_QUOTIENT;
          remainder_d   = sgn_dvd_q ? -dvd_q : dvd_q;
          div_by_zero_d = 1'b1;
        end else begin
          // Truncating division: quotient sign = XOR of signs, remainder
          // takes the dividend's sign.
          quotient_d    = (sgn_dvd_q ^ sgn_dvs_q) ? -q_q : q_q;
          remainder_d   = sgn_dvd_q ? -rem_q : rem_q;
          div_by_zero_d = 1'b0;
        end
        state_d = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort beats everything, including a same-cycle start; results are kept.
    if (flush) begin
      state_d       = ST_IDLE;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      q_q           <= '0;
      sgn_dvd_q     <= 1'b0;
      sgn_dvs_q     <= 1'b0;
      cnt_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      rem_q         <= rem_d;
      q_q           <= q_d;
      sgn_dvd_q     <= sgn_dvd_d;
      sgn_dvs_q     <= sgn_dvs_d;
      cnt_q         <= cnt_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule : mips_div_unit
`default_nettype wire
